layer_mac_engine: RTL
=====================

Name: layer_mac_engine

Overview:
- Consumer stage directly downstream of the weight RAM.
- On a start pulse it walks every neuron row of one layer:
  - issues read addresses to the weight RAM;
  - captures each returned weight row;
  - multiply-accumulates the row against a latched input activation vector;
  - applies optional ReLU and writes the result into an output activation vector.
- Feeds the next layer's input vector and the top-level sequencer.

Parameters:
- MAX_NEURONS, 8, row length and maximum neuron count per layer; must match the weight RAM.
- MAX_DEPTH, 4, number of layers addressable in the weight RAM.
- DATA_W, 32, signed width of weights, activations and results.
- ACC_W, 72, signed accumulator width (2*DATA_W + ceil(log2 MAX_NEURONS) + guard).

Ports:
- CLK  in  1  Sole clock, rising edge.
- RST_N  in  1  Asynchronous active-low reset.
- start  in  1  One-cycle pulse to begin a layer; sampled only in IDLE.
- layer_sel  in  32  Layer to evaluate; latched on start.
- num_neurons  in  32  Output neurons in this layer; latched on start.
- num_inputs  in  32  Active inputs per neuron; latched on start.
- relu_en  in  1  Apply ReLU to each result; latched on start.
- act_in  in  MAX_NEURONS*DATA_W  Input activation vector; latched on start.
- w_rw  out  1  Weight RAM read/write select; constant 0 (read).
- w_layer_index  out  32  Weight RAM layer address.
- w_neuron_index  out  32  Weight RAM row address.
- w_row  in  MAX_NEURONS*DATA_W  Weight RAM registered row output.
- busy  out  1  High from the cycle after start until DONE exits.
- res_valid  out  1  One-cycle pulse when one neuron result is written.
- res_index  out  32  Neuron index of the current res_valid.
- res_data  out  DATA_W  Result accompanying res_valid.
- act_out  out  MAX_NEURONS*DATA_W  Output activation vector.
- done  out  1  One-cycle pulse when the layer is complete.

Behaviour:
- Reset (async, RST_N=0) forces:
  - state IDLE;
  - busy=0, res_valid=0, done=0, w_rw=0;
  - w_layer_index=0, w_neuron_index=0, res_index=0, res_data=0;
  - act_out all zero, accumulator and counters zero.
- Reset mid-layer aborts immediately. No partial done is ever issued.
- Weight RAM contract: address presented in cycle t; w_row is valid from the edge ending cycle t+1, so it is sampled in cycle t+2 (one cycle of registered latency).
- FSM states:
  - IDLE: wait for start. On start:
    - latch all inputs;
    - clamp num_neurons and num_inputs to MAX_NEURONS;
    - if layer_sel is outside 0..MAX_DEPTH-1, go to DONE with act_out cleared.
    - Otherwise, if the clamped num_neurons is 0, go to DONE; else go to REQ with n=0.
  - REQ: drive w_layer_index=layer_sel and w_neuron_index=n. Go to WAIT.
  - WAIT: addresses held. Go to LATCH.
  - LATCH: capture w_row into a local row register; clear acc; k=0. Go to MAC.
  - MAC, one product per cycle:
    - acc += sext(w[k]) * sext(a[k]); k++;
    - after the product with k = num_inputs-1, go to STORE;
    - if num_inputs = 0, go straight to STORE with acc=0.
  - STORE:
    - r = acc saturated to signed DATA_W (max 2^(DATA_W-1)-1, min -2^(DATA_W-1));
    - if relu_en and r<0, then r=0;
    - write act_out[n]=r; pulse res_valid with res_index=n, res_data=r;
    - n++; go to REQ if n < num_neurons, else DONE.
  - DONE: pulse done for one cycle; busy drops the cycle after. Return to IDLE.
- Latency:
  - per neuron = num_inputs + 4 cycles (REQ, WAIT, LATCH, MAC×num_inputs, STORE; num_inputs=0 gives 4);
  - layer = num_neurons*(num_inputs+4) + 1 cycles from start to done.
- Timing and hazards:
  - start while busy is ignored.
  - act_out entries at or above num_neurons retain their previous value, except after the invalid-layer clear.
  - act_in changes after start have no effect.
  - act_out is stable whenever busy=0.

Decomposition:
- Shared package holds:
  - MAX_NEURONS, MAX_DEPTH, DATA_W;
  - ARR row typedef (array of MAX_NEURONS signed DATA_W);
  - saturate-to-DATA_W function.
- One sub-module: mac_unit (signed multiply, accumulate, clear, saturate and ReLU output), instanced once.

Test Plan:
- Weights all 1, act_in=[1..8], layer 0, num_neurons=8, num_inputs=8, relu_en=0 -> eight res_valid with res_data=36; done exactly 97 cycles after start.
- Row n weights = -1, act_in all 5, num_inputs=4, relu_en=1 -> all results 0. Same with relu_en=0 -> all -20.
- Weights 0x7FFFFFFF, act_in 0x7FFFFFFF, num_inputs=8 -> res_data=0x7FFFFFFF (saturation). Negative mirror case -> 0x80000000.
- num_neurons=0 -> done one cycle after IDLE exit, no res_valid. layer_sel=MAX_DEPTH -> done, act_out all 0.
- Second start pulse mid-layer -> ignored, counts unchanged.
- RST_N low during MAC -> outputs zero immediately; fresh start after release gives the correct full layer.
- w_rw=0 throughout; addresses stable from REQ through LATCH.

Source files
------------

// File: rtl/layer_mac_engine_pkg.sv
// rtl/layer_mac_engine_pkg.sv - shared sizes, row type, FSM states and saturation helper
package layer_mac_engine_pkg;
    localparam int MAX_NEURONS = 8;
    localparam int MAX_DEPTH   = 4;
    localparam int DATA_W      = 32;
    localparam int ACC_W       = 72;
    localparam int IDX_W       = $clog2(MAX_NEURONS);
    localparam int CNT_W       = IDX_W + 1;

    typedef logic [MAX_NEURONS-1:0][DATA_W-1:0] arr_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_WAIT, ST_LATCH, ST_MAC, ST_STORE, ST_DONE
    } state_t;

    // In range only when every bit above the DATA_W sign bit matches it.
    function automatic logic [DATA_W-1:0] sat_data(input logic [ACC_W-1:0] v);
        logic [ACC_W-DATA_W:0] top;
        top = v[ACC_W-1:DATA_W-1];
        if ((&top) || !(|top))
            return v[DATA_W-1:0];
        else if (v[ACC_W-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction
endpackage

// File: rtl/layer_mac_engine_mac_unit.sv
// rtl/layer_mac_engine_mac_unit.sv - signed multiply-accumulate with saturating, optional ReLU result
module mac_unit
    import layer_mac_engine_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_w,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic                     i_relu,
    output logic [DATA_W-1:0]        o_result
);
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]          w_sat;

    assign w_prod = i_w * i_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    end

    assign w_sat    = sat_data(r_acc);
    assign o_result = (i_relu && w_sat[DATA_W-1]) ? '0 : w_sat;
endmodule

// File: rtl/layer_mac_engine.sv
// rtl/layer_mac_engine.sv - walks one layer's weight rows and produces the output activation vector
module layer_mac_engine
    import layer_mac_engine_pkg::*;
(
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          start,
    input  logic [31:0]                   layer_sel,
    input  logic [31:0]                   num_neurons,
    input  logic [31:0]                   num_inputs,
    input  logic                          relu_en,
    input  logic [MAX_NEURONS*DATA_W-1:0] act_in,
    output logic                          w_rw,
    output logic [31:0]                   w_layer_index,
    output logic [31:0]                   w_neuron_index,
    input  logic [MAX_NEURONS*DATA_W-1:0] w_row,
    output logic                          busy,
    output logic                          res_valid,
    output logic [31:0]                   res_index,
    output logic [DATA_W-1:0]             res_data,
    output logic [MAX_NEURONS*DATA_W-1:0] act_out,
    output logic                          done
);
    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_nn, r_ni, r_n, r_k;
    logic              r_relu;
    arr_t              r_act_in, r_row, r_act;
    logic [31:0]       r_w_layer, r_w_neuron, r_res_index;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic [CNT_W-1:0]  w_nn_clamp, w_ni_clamp;
    logic              w_bad_layer;
    logic [DATA_W-1:0] w_result;

    assign w_nn_clamp  = (num_neurons > 32'(MAX_NEURONS)) ? CNT_W'(MAX_NEURONS) : num_neurons[CNT_W-1:0];
    assign w_ni_clamp  = (num_inputs  > 32'(MAX_NEURONS)) ? CNT_W'(MAX_NEURONS) : num_inputs[CNT_W-1:0];
    assign w_bad_layer = (layer_sel >= 32'(MAX_DEPTH));

    mac_unit u_mac (
        .clk      (CLK),
        .rst_n    (RST_N),
        .i_clr    (r_state == ST_LATCH),
        .i_en     (r_state == ST_MAC),
        .i_w      (r_row[r_k[IDX_W-1:0]]),
        .i_a      (r_act_in[r_k[IDX_W-1:0]]),
        .i_relu   (r_relu),
        .o_result (w_result)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = (w_bad_layer || w_nn_clamp == '0) ? ST_DONE : ST_REQ;
            ST_REQ:   w_next = ST_WAIT;
            ST_WAIT:  w_next = ST_LATCH;
            ST_LATCH: w_next = (r_ni == '0) ? ST_STORE : ST_MAC;
            ST_MAC:   if (r_k == r_ni - 1'b1) w_next = ST_STORE;
            ST_STORE: w_next = (r_n + 1'b1 < r_nn) ? ST_REQ : ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Weight RAM addresses change only on entry to REQ so they hold through LATCH.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_nn <= '0; r_ni <= '0; r_n <= '0; r_k <= '0; r_relu <= 1'b0;
            r_act_in <= '0; r_row <= '0; r_act <= '0;
            r_w_layer <= '0; r_w_neuron <= '0;
            r_res_valid <= 1'b0; r_res_index <= '0; r_res_data <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_nn     <= w_nn_clamp;
                    r_ni     <= w_ni_clamp;
                    r_relu   <= relu_en;
                    r_act_in <= act_in;
                    r_n      <= '0;
                    if (w_bad_layer)
                        r_act <= '0;
                    else if (w_nn_clamp != '0) begin
                        r_w_layer  <= layer_sel;
                        r_w_neuron <= '0;
                    end
                end
                ST_LATCH: begin
                    r_row <= w_row;
                    r_k   <= '0;
                end
                ST_MAC: r_k <= r_k + 1'b1;
                ST_STORE: begin
                    r_act[r_n[IDX_W-1:0]] <= w_result;
                    r_res_valid <= 1'b1;
                    r_res_index <= 32'(r_n);
                    r_res_data  <= w_result;
                    r_n         <= r_n + 1'b1;
                    if (r_n + 1'b1 < r_nn)
                        r_w_neuron <= 32'(r_n + 1'b1);
                end
                default: ;
            endcase
        end
    end

    assign w_rw           = 1'b0;
    assign w_layer_index  = r_w_layer;
    assign w_neuron_index = r_w_neuron;
    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign res_valid      = r_res_valid;
    assign res_index      = r_res_index;
    assign res_data       = r_res_data;
    assign act_out        = r_act;
endmodule
